// File: rtl/m_fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// m_fetch_controller_pkg : shared fetch FSM states, redirect kinds, panic vector
// Revision 1.0
// ============================================================================
package m_fetch_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    // Encoding doubles as priority rank: a larger value wins.
    typedef enum logic [2:0] {
        RD_NONE  = 3'd0,
        RD_PANIC = 3'd1,
        RD_JMP   = 3'd2,
        RD_BR    = 3'd3,
        RD_EXC   = 3'd4
    } redir_kind_e;

    localparam logic [31:0] PANIC_PC_DEFAULT = 32'h00002000;

    function automatic logic kind_outranks(input redir_kind_e a, input redir_kind_e b);
        return a > b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_fetch_controller_if.sv
`default_nettype none
// ============================================================================
// m_fetch_controller_if : I-cache request/response and decode handoff bus
// Revision 1.0
// ============================================================================
interface m_fetch_controller_if;

    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output ic_req, ic_addr, if_valid, if_instr, if_pc,
        input  ic_ready, ic_rvalid, ic_rdata, if_ready
    );

    modport slave (
        input  ic_req, ic_addr, if_valid, if_instr, if_pc,
        output ic_ready, ic_rvalid, ic_rdata, if_ready
    );

endinterface

`default_nettype wire

// File: rtl/m_redirect_arbiter.sv
`default_nettype none
// ============================================================================
// m_redirect_arbiter : picks the winning redirect and ranks it against a pending one
// Revision 1.0
// ============================================================================
module m_redirect_arbiter
    import m_fetch_controller_pkg::*;
#(
    parameter logic [31:0] PANIC_PC = PANIC_PC_DEFAULT
) (
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        br_valid,
    input  logic [12:0] br_offset,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        panic_req,
    input  redir_kind_e pend_kind,
    output redir_kind_e sel_kind,
    output logic [31:0] sel_target,
    output logic        sel_outranks
);

    always_comb begin
        sel_kind   = RD_NONE;
        sel_target = '0;
        if (exc_valid) begin
            sel_kind   = RD_EXC;
            sel_target = exc_target;
        end else if (br_valid) begin
            sel_kind   = RD_BR;
            sel_target = {19'd0, br_offset};
        end else if (jmp_valid) begin
            sel_kind   = RD_JMP;
            sel_target = jmp_target;
        end else if (panic_req) begin
            sel_kind   = RD_PANIC;
            sel_target = PANIC_PC;
        end
    end

    assign sel_outranks = kind_outranks(sel_kind, pend_kind);

endmodule

`default_nettype wire

// File: rtl/m_fetch_controller.sv
`default_nettype none
// ============================================================================
// m_fetch_controller : I-cache fetch FSM with redirect draining and timeout flag
// Revision 1.0
// ============================================================================
module m_fetch_controller
    import m_fetch_controller_pkg::*;
#(
    parameter logic [31:0] PANIC_PC = PANIC_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                pc,
    input  logic                       exc_valid,
    input  logic [31:0]                exc_target,
    input  logic                       br_valid,
    input  logic [12:0]                br_offset,
    input  logic                       jmp_valid,
    input  logic [31:0]                jmp_target,
    input  logic                       panic_req,
    m_fetch_controller_if.master       bus,
    output logic                       pc_stall,
    output logic                       pc_branch,
    output logic                       pc_jump,
    output logic                       pc_exception,
    output logic                       pc_panic,
    output logic [12:0]                pc_branch_target,
    output logic [31:0]                pc_jump_target,
    output logic [31:0]                pc_exception_target,
    output logic                       fetch_timeout
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(TIMEOUT - 2);

    fetch_state_e     r_state, w_next;
    redir_kind_e      r_pend_kind;
    logic [31:0]      r_pend_tgt;
    logic [31:0]      r_hold_instr;
    logic [31:0]      r_hold_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    redir_kind_e      w_sel_kind;
    logic [31:0]      w_sel_tgt;
    logic             w_sel_outranks;
    logic             w_redir;
    redir_kind_e      w_apply_kind;
    logic [31:0]      w_apply_tgt;
    logic             w_latch;
    logic             w_clr;
    logic             w_capture;
    logic             w_waiting;

    m_redirect_arbiter #(
        .PANIC_PC (PANIC_PC)
    ) u_arb (
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .br_valid     (br_valid),
        .br_offset    (br_offset),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .panic_req    (panic_req),
        .pend_kind    (r_pend_kind),
        .sel_kind     (w_sel_kind),
        .sel_target   (w_sel_tgt),
        .sel_outranks (w_sel_outranks)
    );

    assign w_redir   = (w_sel_kind != RD_NONE);
    assign w_waiting = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        pc_stall     = 1'b1;
        w_apply_kind = RD_NONE;
        w_apply_tgt  = '0;
        w_latch      = 1'b0;
        w_clr        = 1'b0;
        w_capture    = 1'b0;
        bus.ic_req   = 1'b0;
        bus.ic_addr  = '0;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;

        case (r_state)
            ST_IDLE: begin
                // Strobes must stay quiet while reset is held, even if a redirect is asserted.
                if (reset_n && w_redir) begin
                    w_apply_kind = w_sel_kind;
                    w_apply_tgt  = w_sel_tgt;
                    pc_stall     = 1'b0;
                end
                w_next = ST_REQ;
            end

            ST_REQ: begin
                bus.ic_req  = 1'b1;
                bus.ic_addr = pc;
                if (bus.ic_ready) begin
                    if (w_redir) begin
                        w_latch = 1'b1;
                        w_next  = ST_DRAIN;
                    end else begin
                        w_next  = ST_WAIT;
                    end
                end else if (w_redir) begin
                    w_apply_kind = w_sel_kind;
                    w_apply_tgt  = w_sel_tgt;
                    pc_stall     = 1'b0;
                    w_next       = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (w_redir) begin
                    if (bus.ic_rvalid) begin
                        w_apply_kind = w_sel_kind;
                        w_apply_tgt  = w_sel_tgt;
                        pc_stall     = 1'b0;
                        w_next       = ST_REQ;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = ST_DRAIN;
                    end
                end else if (bus.ic_rvalid) begin
                    bus.if_valid = 1'b1;
                    bus.if_instr = bus.ic_rdata;
                    bus.if_pc    = pc;
                    if (bus.if_ready) begin
                        pc_stall = 1'b0;
                        w_next   = ST_REQ;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (w_redir) begin
                    w_apply_kind = w_sel_kind;
                    w_apply_tgt  = w_sel_tgt;
                    pc_stall     = 1'b0;
                    w_next       = ST_REQ;
                end else begin
                    bus.if_valid = 1'b1;
                    bus.if_instr = r_hold_instr;
                    bus.if_pc    = r_hold_pc;
                    if (bus.if_ready) begin
                        pc_stall = 1'b0;
                        w_next   = ST_REQ;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.ic_rvalid) begin
                    // A stronger redirect arriving with the response wins over the pending one.
                    if (w_sel_outranks) begin
                        w_apply_kind = w_sel_kind;
                        w_apply_tgt  = w_sel_tgt;
                    end else begin
                        w_apply_kind = r_pend_kind;
                        w_apply_tgt  = r_pend_tgt;
                    end
                    pc_stall = 1'b0;
                    w_clr    = 1'b1;
                    w_next   = ST_REQ;
                end else if (w_sel_outranks) begin
                    w_latch = 1'b1;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign pc_exception        = (w_apply_kind == RD_EXC);
    assign pc_branch           = (w_apply_kind == RD_BR);
    assign pc_jump             = (w_apply_kind == RD_JMP);
    assign pc_panic            = (w_apply_kind == RD_PANIC);
    assign pc_exception_target = pc_exception ? w_apply_tgt        : '0;
    assign pc_jump_target      = pc_jump      ? w_apply_tgt        : '0;
    assign pc_branch_target    = pc_branch    ? w_apply_tgt[12:0]  : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_kind <= RD_NONE;
            r_pend_tgt  <= '0;
        end else if (w_clr) begin
            r_pend_kind <= RD_NONE;
            r_pend_tgt  <= '0;
        end else if (w_latch) begin
            r_pend_kind <= w_sel_kind;
            r_pend_tgt  <= w_sel_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else if (w_capture) begin
            r_hold_instr <= bus.ic_rdata;
            r_hold_pc    <= pc;
        end
    end

    // The flag rises in the same cycle the counter lands on its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_waiting && !bus.ic_rvalid) begin
            if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CNT_ARM) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign fetch_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_m_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_m_fetch_controller : table-driven check of the fetch controller with a PC model
// Revision 1.0
// ============================================================================
module tb_m_fetch_controller;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ifr;
        logic [3:0]  rd;      // {exc, br, jmp, panic}
        logic [31:0] rval;
        logic        e_req;
        logic [31:0] e_addr;  // ic_addr when requesting, if_pc when presenting
        logic        e_ifv;
        logic [31:0] e_instr;
        logic        e_stall;
        logic [3:0]  e_strb;  // {exc, br, jmp, panic}
        logic [31:0] e_tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_target = '0;
    logic        br_valid = 1'b0;
    logic [12:0] br_offset = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        panic_req = 1'b0;
    logic        pc_stall, pc_branch, pc_jump, pc_exception, pc_panic;
    logic [12:0] pc_branch_target;
    logic [31:0] pc_jump_target, pc_exception_target;
    logic        fetch_timeout;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    m_fetch_controller_if bus ();

    m_fetch_controller #(
        .PANIC_PC (32'h00002000),
        .TIMEOUT  (64)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .pc                  (pc),
        .exc_valid           (exc_valid),
        .exc_target          (exc_target),
        .br_valid            (br_valid),
        .br_offset           (br_offset),
        .jmp_valid           (jmp_valid),
        .jmp_target          (jmp_target),
        .panic_req           (panic_req),
        .bus                 (bus),
        .pc_stall            (pc_stall),
        .pc_branch           (pc_branch),
        .pc_jump             (pc_jump),
        .pc_exception        (pc_exception),
        .pc_panic            (pc_panic),
        .pc_branch_target    (pc_branch_target),
        .pc_jump_target      (pc_jump_target),
        .pc_exception_target (pc_exception_target),
        .fetch_timeout       (fetch_timeout)
    );

    always #5 clk = ~clk;

    // Program counter model following the controller's strobes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= 32'h00001000;
        end else if (!pc_stall) begin
            if (pc_exception)   pc <= pc_exception_target;
            else if (pc_branch) pc <= pc + {{17{pc_branch_target[12]}}, pc_branch_target, 2'b00};
            else if (pc_jump)   pc <= pc_jump_target;
            else if (pc_panic)  pc <= 32'h00002000;
            else                pc <= pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata, input logic ifr,
                       input logic [3:0] rd, input logic [31:0] rval,
                       input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                       input logic [31:0] e_instr, input logic e_stall, input logic [3:0] e_strb,
                       input logic [31:0] e_tgt);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ifr = ifr; v.rd = rd; v.rval = rval;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_instr = e_instr;
        v.e_stall = e_stall; v.e_strb = e_strb; v.e_tgt = e_tgt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata, input logic ifr,
                         input logic [3:0] rd, input logic [31:0] rval);
        bus.ic_ready  = rdy;
        bus.ic_rvalid = rv;
        bus.ic_rdata  = rdata;
        bus.if_ready  = ifr;
        exc_valid     = rd[3];
        br_valid      = rd[2];
        jmp_valid     = rd[1];
        panic_req     = rd[0];
        exc_target    = rval;
        jmp_target    = rval;
        br_offset     = rval[12:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctrl_now();
        return {bus.ic_req, bus.if_valid, pc_stall, pc_exception, pc_branch, pc_jump, pc_panic, fetch_timeout};
    endfunction

    task automatic check_row(input int idx, input vec_t v);
        logic [31:0]  a_addr, a_instr, a_tgt, e_addr, e_instr, e_tgt;
        a_addr  = v.e_req ? bus.ic_addr : (v.e_ifv ? bus.if_pc : 32'd0);
        a_instr = v.e_ifv ? bus.if_instr : 32'd0;
        a_tgt   = v.e_strb[3] ? pc_exception_target :
                  v.e_strb[2] ? {19'd0, pc_branch_target} :
                  v.e_strb[1] ? pc_jump_target : 32'd0;
        e_addr  = (v.e_req || v.e_ifv) ? v.e_addr : 32'd0;
        e_instr = v.e_ifv ? v.e_instr : 32'd0;
        e_tgt   = (v.e_strb[3:1] != 3'b000) ? v.e_tgt : 32'd0;
        chk($sformatf("row%0d", idx),
            {24'd0, ctrl_now(), a_addr, a_instr, a_tgt},
            {24'd0, v.e_req, v.e_ifv, v.e_stall, v.e_strb, 1'b0, e_addr, e_instr, e_tgt});
    endtask

    initial begin
        drive(0, 0, 0, 0, 4'h0, 0);

        // rdy rv rdata ifr rd val | req addr ifv instr stall strb tgt
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h1000,     0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hA0A0A0A0, 1, 4'h0, 0,            0, 32'h1000,     1, 32'hA0A0A0A0, 0, 4'h0, 0);
        add(1, 0, 0,            1, 4'h0, 0,            1, 32'h1004,     0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hA1A1A1A1, 1, 4'h0, 0,            0, 32'h1004,     1, 32'hA1A1A1A1, 0, 4'h0, 0);
        add(1, 0, 0,            1, 4'h0, 0,            1, 32'h1008,     0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hA2A2A2A2, 0, 4'h0, 0,            0, 32'h1008,     1, 32'hA2A2A2A2, 1, 4'h0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0,        0, 4'h0, 0,            0, 32'h1008,     1, 32'hA2A2A2A2, 1, 4'h0, 0);
        add(0, 0, 0,            1, 4'h0, 0,            0, 32'h1008,     1, 32'hA2A2A2A2, 0, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            1, 32'h100C,     0, 0,            1, 4'h0, 0);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h100C,     0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h2, 32'h3000,     0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h0, 0,            0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hDEADDEAD, 1, 4'h0, 0,            0, 0,            0, 0,            0, 4'h2, 32'h3000);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h3000,     0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h2, 32'h4000,     0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h8, 32'h0100,     0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 0, 0,            0, 4'h2, 32'h6000,     0, 0,            0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hBEEFBEEF, 1, 4'h0, 0,            0, 0,            0, 0,            0, 4'h8, 32'h0100);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h0100,     0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hB0B0B0B0, 0, 4'h0, 0,            0, 32'h0100,     1, 32'hB0B0B0B0, 1, 4'h0, 0);
        add(0, 0, 0,            0, 4'hC, 32'h0200,     0, 0,            0, 0,            0, 4'h8, 32'h0200);
        add(0, 0, 0,            0, 4'h4, 32'h0005,     1, 32'h0200,     0, 0,            0, 4'h4, 32'h0005);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h0214,     0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hC0C0C0C0, 1, 4'h1, 0,            0, 0,            0, 0,            0, 4'h1, 0);
        add(1, 0, 0,            0, 4'h2, 32'h5000,     1, 32'h2000,     0, 0,            1, 4'h0, 0);
        add(0, 1, 32'hC1C1C1C1, 1, 4'h0, 0,            0, 0,            0, 0,            0, 4'h2, 32'h5000);
        add(1, 0, 0,            0, 4'h0, 0,            1, 32'h5000,     0, 0,            1, 4'h0, 0);

        // Reset state, with an exception request held high to prove strobes stay quiet.
        step();
        step();
        drive(1, 1, 32'h12345678, 1, 4'h8, 32'h0300);
        #3;
        chk("reset_outputs", {120'd0, ctrl_now()}, {120'd0, 8'b0010_0000});
        step();
        drive(0, 0, 0, 0, 4'h0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rdy, vq[i].rv, vq[i].rdata, vq[i].ifr, vq[i].rd, vq[i].rval);
            #3;
            check_row(i, vq[i]);
            step();
        end

        // Response withheld: flag rises on the 64th waiting cycle and sticks.
        drive(0, 0, 0, 0, 4'h0, 0);
        for (int k = 1; k <= 64; k++) begin
            #3;
            if (k == 63) chk("timeout_early", {127'd0, fetch_timeout}, {127'd0, 1'b0});
            if (k == 64) chk("timeout_rise", {120'd0, ctrl_now()}, {120'd0, 8'b0010_0001});
            step();
        end
        for (int k = 0; k < 6; k++) step();
        #3;
        chk("timeout_sticky", {120'd0, ctrl_now()}, {120'd0, 8'b0010_0001});
        step();
        drive(0, 1, 32'hD0D0D0D0, 1, 4'h0, 0);
        #3;
        chk("late_resp", {24'd0, ctrl_now(), bus.if_pc, bus.if_instr, 32'd0},
            {24'd0, 8'b0100_0001, 32'h5000, 32'hD0D0D0D0, 32'd0});
        step();
        drive(1, 0, 0, 0, 4'h0, 0);
        #3;
        chk("after_timeout_req", {88'd0, ctrl_now(), bus.ic_addr}, {88'd0, 8'b1010_0001, 32'h5004});
        step();

        // Reset while a request is outstanding, then a stale response in IDLE.
        drive(0, 0, 0, 0, 4'h0, 0);
        reset_n = 1'b0;
        #3;
        chk("reset_midfetch", {120'd0, ctrl_now()}, {120'd0, 8'b0010_0000});
        step();
        reset_n = 1'b1;
        drive(0, 1, 32'hEEEEEEEE, 1, 4'h0, 0);
        #3;
        chk("idle_stale_resp", {120'd0, ctrl_now()}, {120'd0, 8'b0010_0000});
        step();
        drive(0, 0, 0, 0, 4'h0, 0);
        #3;
        chk("restart_req", {88'd0, ctrl_now(), bus.ic_addr}, {88'd0, 8'b1010_0000, 32'h1000});
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
